// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship blocks: room indices,
// hazard scheduler states and the LFSR constants.
package nexys_starship_pkg;

  // Room indices, matching bit positions of the broken/break_req buses
  localparam logic [1:0] ROOM_L = 2'd0;
  localparam logic [1:0] ROOM_R = 2'd1;
  localparam logic [1:0] ROOM_U = 2'd2;
  localparam logic [1:0] ROOM_D = 2'd3;

  // Hazard scheduler states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIRE = 2'd2
  } hz_state_e;

  // 16-bit Fibonacci LFSR: taps 16/14/13/11 -> state bits 15/13/12/10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One-hot request vector for a room index
  function automatic logic [3:0] room_onehot(input logic [1:0] room);
    room_onehot = 4'b0001 << room;
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts every cycle, never all-zero.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] o_state
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = ^(r_lfsr & LFSR_TAPS);
  assign o_state    = r_lfsr;

  // Shift left, feeding the XOR of the tap bits into bit 0
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_feedback};
    end
  end

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// Breakdown scheduler: fires one-cycle break requests with a repair combo
// at rooms that are not already broken, shortening the interval over time.
module nexys_starship_hazard_gen
  import nexys_starship_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned BASE_INTERVAL = 8,
  parameter int unsigned MIN_INTERVAL  = 2,
  parameter int unsigned STEP          = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken,
  output logic [3:0] break_req,
  output logic [3:0] random_hex,
  output logic [7:0] fire_count,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Fire
);

  localparam int unsigned IW = $clog2(BASE_INTERVAL + 1);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] INT_BASE  = IW'(BASE_INTERVAL);
  localparam logic [IW-1:0] INT_MIN   = IW'(MIN_INTERVAL);
  localparam logic [IW-1:0] CD_ONE    = IW'(1);

  hz_state_e   r_state;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_countdown;
  logic [IW-1:0] r_interval;
  logic [3:0]    r_break_req;
  logic [3:0]    r_random_hex;
  logic [7:0]    r_fire_count;

  logic [15:0]   w_lfsr;
  logic          w_found;
  logic [1:0]    w_room;
  logic [IW-1:0] w_next_interval;

  nexys_starship_lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset   (Reset),
    .o_state (w_lfsr)
  );

  // Rotate from the random candidate and take the first room not broken
  always_comb begin
    w_found = 1'b0;
    w_room  = w_lfsr[1:0];
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_found && !broken[w_lfsr[1:0] + 2'(k)]) begin
        w_found = 1'b1;
        w_room  = w_lfsr[1:0] + 2'(k);
      end
    end
  end

  // Decayed interval, clamped at the floor (signed math avoids underflow)
  always_comb begin
    if ((int'(r_interval) - int'(STEP)) > int'(MIN_INTERVAL)) begin
      w_next_interval = IW'(int'(r_interval) - int'(STEP));
    end else begin
      w_next_interval = INT_MIN;
    end
  end

  // Scheduler FSM with registered request/combo outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_countdown  <= INT_BASE;
      r_interval   <= INT_BASE;
      r_break_req  <= '0;
      r_random_hex <= '0;
      r_fire_count <= '0;
    end else begin
      r_break_req <= '0;
      if (gameover_ctrl) begin
        r_state      <= S_IDLE;
        r_presc      <= '0;
        r_countdown  <= INT_BASE;
        r_interval   <= INT_BASE;
        r_fire_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_presc      <= '0;
            r_countdown  <= INT_BASE;
            r_interval   <= INT_BASE;
            r_fire_count <= '0;
            if (play_flag) r_state <= S_RUN;
          end
          S_RUN: begin
            if (r_presc == PRESC_MAX) begin
              r_presc <= '0;
              if (r_countdown <= CD_ONE) begin
                r_state <= S_FIRE;
              end else begin
                r_countdown <= r_countdown - 1'b1;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          S_FIRE: begin
            // Countdown reloads with the interval in force after this fire
            if (w_found) begin
              r_break_req  <= room_onehot(w_room);
              r_random_hex <= w_lfsr[7:4];
              if (r_fire_count != 8'hFF) r_fire_count <= r_fire_count + 8'd1;
              r_interval   <= w_next_interval;
              r_countdown  <= w_next_interval;
            end else begin
              r_countdown  <= r_interval;
            end
            r_presc <= '0;
            r_state <= S_RUN;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign break_req  = r_break_req;
  assign random_hex = r_random_hex;
  assign fire_count = r_fire_count;
  assign q_Idle     = (r_state == S_IDLE);
  assign q_Run      = (r_state == S_RUN);
  assign q_Fire     = (r_state == S_FIRE);

endmodule

// File: tb/tb_nexys_starship_hazard_gen.sv
// Bench for the hazard scheduler: directed vector table, randomized traffic
// against a cycle-level reference model, and an asynchronous reset sequence.
module tb_nexys_starship_hazard_gen;

  localparam int TD   = 4;
  localparam int BASE = 3;
  localparam int MINI = 1;
  localparam int STP  = 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FIRE = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic [3:0] broken = 4'b0000;
  logic [3:0] break_req;
  logic [3:0] random_hex;
  logic [7:0] fire_count;
  logic       q_Idle, q_Run, q_Fire;

  int n_checks = 0;
  int n_fail   = 0;

  nexys_starship_hazard_gen #(
    .TICK_DIV      (TD),
    .BASE_INTERVAL (BASE),
    .MIN_INTERVAL  (MINI),
    .STEP          (STP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .broken        (broken),
    .break_req     (break_req),
    .random_hex    (random_hex),
    .fire_count    (fire_count),
    .q_Idle        (q_Idle),
    .q_Run         (q_Run),
    .q_Fire        (q_Fire)
  );

  always #5 Clk = ~Clk;

  // Reference model: game phase plus a count of RUN cycles left before FIRE
  logic [15:0] m_lfsr;
  int          m_mode, m_wait, m_interval, m_count;
  logic [3:0]  m_req, m_hex;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_mode = M_IDLE; m_wait = 0;
    m_interval = BASE; m_count = 0; m_req = 4'b0; m_hex = 4'b0;
  endtask

  task automatic model_step(input logic p, input logic g, input logic [3:0] b);
    int sel;
    bit found;
    m_req = 4'b0;
    if (g) begin
      m_mode = M_IDLE; m_count = 0; m_interval = BASE;
    end else if (m_mode == M_IDLE) begin
      m_count = 0; m_interval = BASE;
      if (p) begin m_mode = M_RUN; m_wait = m_interval * TD; end
    end else if (m_mode == M_RUN) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) m_mode = M_FIRE;
    end else begin
      found = 0; sel = 0;
      for (int k = 0; k < 4; k++) begin
        int r;
        r = (int'(m_lfsr[1:0]) + k) % 4;
        if (!found && !b[r]) begin found = 1; sel = r; end
      end
      if (found) begin
        m_req = 4'(1 << sel);
        m_hex = m_lfsr[7:4];
        m_count = (m_count < 255) ? m_count + 1 : 255;
        m_interval = (m_interval - STP > MINI) ? m_interval - STP : MINI;
      end
      m_wait = m_interval * TD;
      m_mode = M_RUN;
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [2:0] q_exp;
    q_exp = (m_mode == M_IDLE) ? 3'b100 : (m_mode == M_RUN) ? 3'b010 : 3'b001;
    chk("break_req", 16'(break_req), 16'(m_req));
    chk("random_hex", 16'(random_hex), 16'(m_hex));
    chk("fire_count", 16'(fire_count), 16'(m_count));
    chk("state", 16'({q_Idle, q_Run, q_Fire}), 16'(q_exp));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it
  task automatic cycle(input logic p, input logic g, input logic [3:0] b);
    play_flag = p; gameover_ctrl = g; broken = b;
    @(posedge Clk);
    if (Reset) model_reset(); else model_step(p, g, b);
    #1 check_model();
  endtask

  typedef struct {
    logic       play;
    logic       gover;
    logic [3:0] brk;
    int         ncyc;
    logic [3:0] exp_req;
    logic [7:0] exp_cnt;
    logic [2:0] exp_q;   // {idle, run, fire}
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit any_pulse;
    vecs[0]  = '{1'b1, 1'b0, 4'b1101,  1, 4'b0000, 8'd0, 3'b010};
    vecs[1]  = '{1'b0, 1'b0, 4'b1101, 12, 4'b0000, 8'd0, 3'b001};
    vecs[2]  = '{1'b0, 1'b0, 4'b1101,  1, 4'b0010, 8'd1, 3'b010};
    vecs[3]  = '{1'b0, 1'b0, 4'b1101,  8, 4'b0000, 8'd1, 3'b001};
    vecs[4]  = '{1'b0, 1'b0, 4'b1101,  1, 4'b0010, 8'd2, 3'b010};
    vecs[5]  = '{1'b0, 1'b0, 4'b1101,  4, 4'b0000, 8'd2, 3'b001};
    vecs[6]  = '{1'b0, 1'b0, 4'b1101,  1, 4'b0010, 8'd3, 3'b010};
    vecs[7]  = '{1'b0, 1'b0, 4'b1101,  4, 4'b0000, 8'd3, 3'b001};
    vecs[8]  = '{1'b0, 1'b0, 4'b1111,  1, 4'b0000, 8'd3, 3'b010};
    vecs[9]  = '{1'b0, 1'b0, 4'b1111,  4, 4'b0000, 8'd3, 3'b001};
    vecs[10] = '{1'b0, 1'b1, 4'b1101,  1, 4'b0000, 8'd0, 3'b100};
    vecs[11] = '{1'b1, 1'b0, 4'b1101,  1, 4'b0000, 8'd0, 3'b010};
    vecs[12] = '{1'b0, 1'b0, 4'b1101, 12, 4'b0000, 8'd0, 3'b001};
    vecs[13] = '{1'b0, 1'b0, 4'b1101,  1, 4'b0010, 8'd1, 3'b010};

    // Power-on reset with a clean rising edge
    model_reset();
    #1 Reset = 1'b1;
    #2 check_model();
    @(posedge Clk); @(posedge Clk);
    #4 Reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      for (int n = 0; n < vecs[i].ncyc; n++)
        cycle(vecs[i].play, vecs[i].gover, vecs[i].brk);
      chk($sformatf("vec%0d_req", i), 16'(break_req), 16'(vecs[i].exp_req));
      chk($sformatf("vec%0d_cnt", i), 16'(fire_count), 16'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_q", i), 16'({q_Idle, q_Run, q_Fire}), 16'(vecs[i].exp_q));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      logic p, g;
      logic [3:0] b;
      g = ($urandom_range(0, 149) == 0);
      p = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      cycle(p, g, b);
    end

    // Asynchronous reset between clock edges while running
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b1, 1'b0, 4'b0000);
    repeat (30) cycle(1'b0, 1'b0, 4'b0000);
    chk("pre_reset_cnt_nonzero", 16'(fire_count != 8'd0), 16'd1);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("async_req", 16'(break_req), 16'd0);
    chk("async_hex", 16'(random_hex), 16'd0);
    chk("async_cnt", 16'(fire_count), 16'd0);
    chk("async_q", 16'({q_Idle, q_Run, q_Fire}), 16'b100);
    cycle(1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0000);
    #3 Reset = 1'b0;
    any_pulse = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 4'b0000);
      if (break_req != 4'b0000) any_pulse = 1;
    end
    chk("post_reset_no_pulse", 16'(any_pulse), 16'd0);
    chk("post_reset_idle", 16'(q_Idle), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
